mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit; the FSM stage directly upstream of the datapath inside mccomp.
- Consumes opcode/funct from the instruction register and the ALU zero flag.
- Drives every datapath enable and mux select, cycle by cycle, for the shared instruction/data memory (U_DM).
- One instruction occupies 2-5 cycles; memory access stalls on a ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 42 ++++
 rtl/mc_ctrl_decode.sv | 87 ++++++++
 rtl/mc_ctrl.sv | 157 +++++++++++++++
 tb/tb_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct values and ALU operation codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: sorts op/funct into the classes the
// control FSM steers on and picks the ALU operation used in EXE.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int SUPPORT_BNE = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       is_rtype,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_bne,
    output logic       is_jump,
    output logic       is_jal,
    output logic       is_jr,
    output logic       ext_op,
    output logic       legal,
    output logic [3:0] alu_code
);

    // Opcode/funct classification
    always_comb begin
        is_rtype  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        ext_op    = 1'b0;
        legal     = 1'b1;
        alu_code  = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (funct)
                    FN_ADD:  alu_code = ALU_ADD;
                    FN_SUB:  alu_code = ALU_SUB;
                    FN_AND:  alu_code = ALU_AND;
                    FN_OR:   alu_code = ALU_OR;
                    FN_SLT:  alu_code = ALU_SLT;
                    FN_SLL:  alu_code = ALU_SLL;
                    FN_SRL:  alu_code = ALU_SRL;
                    FN_JR: begin
                        is_jump = 1'b1;
                        is_jr   = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_J:    is_jump = 1'b1;
            OP_JAL: begin
                is_jump = 1'b1;
                is_jal  = 1'b1;
            end
            OP_BEQ: begin
                is_branch = 1'b1;
                alu_code  = ALU_SUB;
            end
            OP_BNE: begin
                if (SUPPORT_BNE != 0) begin
                    is_branch = 1'b1;
                    is_bne    = 1'b1;
                    alu_code  = ALU_SUB;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_ADDI: ext_op = 1'b1;
            OP_ORI:  alu_code = ALU_OR;
            OP_LUI:  alu_code = ALU_LUI;
            OP_LW: begin
                is_load = 1'b1;
                ext_op  = 1'b1;
            end
            OP_SW: begin
                is_store = 1'b1;
                ext_op   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB and drives
// every datapath enable and mux select combinationally from the current state.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int SUPPORT_BNE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_write,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic [1:0]         wd_sel,
    output logic [1:0]         gpr_sel,
    output logic               ext_op,
    output logic               illegal,
    output logic               retire
);

    state_e     state_r;
    state_e     state_nxt_s;
    logic       is_rtype_s, is_load_s, is_store_s, is_branch_s, is_bne_s;
    logic       is_jump_s, is_jal_s, is_jr_s, ext_s, legal_s;
    logic [3:0] dec_alu_s;
    logic [3:0] alu_code_s;

    mc_ctrl_decode #(.SUPPORT_BNE(SUPPORT_BNE)) u_decode (
        .op        (op),
        .funct     (funct),
        .is_rtype  (is_rtype_s),
        .is_load   (is_load_s),
        .is_store  (is_store_s),
        .is_branch (is_branch_s),
        .is_bne    (is_bne_s),
        .is_jump   (is_jump_s),
        .is_jal    (is_jal_s),
        .is_jr     (is_jr_s),
        .ext_op    (ext_s),
        .legal     (legal_s),
        .alu_code  (dec_alu_s)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control outputs; reset forces everything to 0
    always_comb begin
        state_nxt_s = S_FETCH;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_code_s  = ALU_ADD;
        pc_source   = 2'b00;
        wd_sel      = 2'b00;
        gpr_sel     = 2'b00;
        ext_op      = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        if (reset) begin
            state_nxt_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write    = 1'b1;
                        pc_write    = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    if (!legal_s) begin
                        illegal     = 1'b1;
                        retire      = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else if (is_jump_s) begin
                        pc_write    = 1'b1;
                        retire      = 1'b1;
                        pc_source   = is_jr_s ? 2'b11 : 2'b10;
                        state_nxt_s = S_FETCH;
                        // jal links the already-incremented PC into $31
                        if (is_jal_s) begin
                            reg_write = 1'b1;
                            gpr_sel   = 2'b10;
                            wd_sel    = 2'b10;
                        end else begin
                            reg_write = 1'b0;
                        end
                    end else begin
                        state_nxt_s = S_EXE;
                    end
                end
                S_EXE: begin
                    alu_src_a  = 1'b1;
                    alu_code_s = dec_alu_s;
                    if (is_branch_s) begin
                        pc_source   = 2'b01;
                        pc_write    = zero ^ is_bne_s;
                        retire      = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else if (is_rtype_s) begin
                        state_nxt_s = S_WB;
                    end else begin
                        alu_src_b   = 2'b10;
                        ext_op      = ext_s;
                        state_nxt_s = (is_load_s || is_store_s) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_write = is_store_s;
                    if (mem_ready) begin
                        retire      = is_store_s;
                        state_nxt_s = is_store_s ? S_FETCH : S_WB;
                    end else begin
                        state_nxt_s = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write   = 1'b1;
                    retire      = 1'b1;
                    wd_sel      = is_load_s ? 2'b01 : 2'b00;
                    gpr_sel     = is_rtype_s ? 2'b00 : 2'b01;
                    state_nxt_s = S_FETCH;
                end
                default: state_nxt_s = S_FETCH;
            endcase
        end
    end

    assign alu_op = ALUOP_W'(alu_code_s);

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: builds the expected per-cycle control trace of each
// instruction from its class and compares it with the DUT every cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] wd_sel;
        logic [1:0] gpr_sel;
        logic       ext_op;
        logic       illegal;
        logic       retire;
    } ctl_t;

    typedef struct {
        logic rst;
        logic mrdy;
        logic z;
        ctl_t exp;
    } step_t;

    typedef enum int {K_R, K_ADDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                      K_J, K_JAL, K_JR, K_ILL} kind_e;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, iord, mem_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, wd_sel, gpr_sel;
    logic [3:0] alu_op;
    logic       ext_op, illegal, retire;

    ctl_t  act;
    ctl_t  exp_r = '0;
    logic  exp_valid = 1'b0;
    string cur_name = "reset";
    int    checks = 0;
    int    errors = 0;
    step_t steps[$];

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .wd_sel(wd_sel), .gpr_sel(gpr_sel),
        .ext_op(ext_op), .illegal(illegal), .retire(retire)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, ir_write, iord, mem_write, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, wd_sel, gpr_sel, ext_op,
                  illegal, retire};

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_r) begin
                errors++;
                $display("FAIL %s: got %06h expected %06h", cur_name, act, exp_r);
            end
        end
    end

    function automatic kind_e classify(logic [5:0] o, logic [5:0] f);
        case (o)
            6'h00: begin
                case (f)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: return K_R;
                    6'h08:   return K_JR;
                    default: return K_ILL;
                endcase
            end
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h08:   return K_ADDI;
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(logic [5:0] f);
        case (f)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            6'h00:   return 4'd5;
            6'h02:   return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(logic r, logic m, logic z, ctl_t e);
        step_t s;
        s.rst = r; s.mrdy = m; s.z = z; s.exp = e;
        steps.push_back(s);
    endtask

    // zmode: 0/1 fixes the zero flag during execute, 2 randomises it
    task automatic build(logic [5:0] o, logic [5:0] f, int fstall, int mstall, int zmode);
        kind_e k;
        ctl_t  e;
        logic  z;
        k = classify(o, f);
        steps.delete();
        for (int i = 0; i < fstall; i++) begin
            e = '0; e.alu_src_b = 2'b01;
            push(1'b0, 1'b0, rbit(), e);
        end
        e = '0; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b0, 1'b1, rbit(), e);
        e = '0; e.alu_src_b = 2'b11;
        if (k == K_ILL) begin
            e.illegal = 1'b1; e.retire = 1'b1;
            push(1'b0, rbit(), rbit(), e);
            return;
        end
        if (k == K_J || k == K_JAL || k == K_JR) begin
            e.pc_write = 1'b1; e.retire = 1'b1;
            e.pc_source = (k == K_JR) ? 2'b11 : 2'b10;
            if (k == K_JAL) begin
                e.reg_write = 1'b1; e.gpr_sel = 2'b10; e.wd_sel = 2'b10;
            end
            push(1'b0, rbit(), rbit(), e);
            return;
        end
        push(1'b0, rbit(), rbit(), e);
        z = (zmode == 2) ? rbit() : 1'(zmode);
        e = '0; e.alu_src_a = 1'b1;
        case (k)
            K_R:    e.alu_op = r_alu(f);
            K_ADDI, K_LW, K_SW: begin e.alu_src_b = 2'b10; e.ext_op = 1'b1; end
            K_ORI:  begin e.alu_src_b = 2'b10; e.alu_op = 4'd3; end
            K_LUI:  begin e.alu_src_b = 2'b10; e.alu_op = 4'd7; end
            default: begin
                e.alu_op = 4'd1; e.pc_source = 2'b01; e.retire = 1'b1;
                e.pc_write = (k == K_BEQ) ? z : ~z;
            end
        endcase
        push(1'b0, rbit(), z, e);
        if (k == K_BEQ || k == K_BNE) return;
        if (k == K_LW || k == K_SW) begin
            e = '0; e.iord = 1'b1; e.mem_write = (k == K_SW);
            for (int i = 0; i < mstall; i++) push(1'b0, 1'b0, rbit(), e);
            e.retire = (k == K_SW);
            push(1'b0, 1'b1, rbit(), e);
            if (k == K_SW) return;
        end
        e = '0; e.reg_write = 1'b1; e.retire = 1'b1;
        e.wd_sel  = (k == K_LW) ? 2'b01 : 2'b00;
        e.gpr_sel = (k == K_R) ? 2'b00 : 2'b01;
        push(1'b0, rbit(), rbit(), e);
    endtask

    // Entry and exit are #1 after a rising edge
    task automatic play(logic [5:0] o, logic [5:0] f);
        for (int i = 0; i < steps.size(); i++) begin
            reset = steps[i].rst; mem_ready = steps[i].mrdy; zero = steps[i].z;
            op = o; funct = f; exp_r = steps[i].exp; exp_valid = 1'b1;
            cur_name = $sformatf("op%02h/fn%02h cyc%0d", o, f, i);
            @(posedge clk); #1;
        end
    endtask

    task automatic pin(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic run(logic [5:0] o, logic [5:0] f, int fs, int ms, int zm);
        build(o, f, fs, ms, zm);
        play(o, f);
    endtask

    logic [11:0] ilist [20] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
        {6'h00, 6'h2A}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h08},
        {6'h00, 6'h3F}, {6'h02, 6'h11}, {6'h03, 6'h05}, {6'h04, 6'h20},
        {6'h05, 6'h01}, {6'h08, 6'h3F}, {6'h0D, 6'h00}, {6'h0F, 6'h08},
        {6'h23, 6'h2A}, {6'h2B, 6'h20}, {6'h3F, 6'h20}, {6'h01, 6'h00}};

    initial begin
        // Reset: all outputs zero even with ready high and a store opcode
        op = 6'h2B; mem_ready = 1'b1; exp_r = '0; exp_valid = 1'b1;
        cur_name = "reset";
        repeat (3) @(posedge clk);
        #1;
        // Latency pins for the model itself
        build(6'h00, 6'h20, 0, 0, 2); pin("lat_add", steps.size(), 4);
        pin("add_wb_regwrite", int'(steps[3].exp.reg_write), 1);
        build(6'h23, 6'h00, 0, 0, 2); pin("lat_lw", steps.size(), 5);
        build(6'h23, 6'h00, 0, 2, 2); pin("lat_lw_stall", steps.size(), 7);
        pin("lw_wb_wdsel", int'(steps[6].exp.wd_sel), 1);
        build(6'h2B, 6'h00, 0, 0, 2); pin("lat_sw", steps.size(), 4);
        build(6'h04, 6'h00, 0, 0, 1); pin("lat_beq", steps.size(), 3);
        pin("beq_taken_pcw", int'(steps[2].exp.pc_write), 1);
        build(6'h03, 6'h00, 0, 0, 2); pin("lat_jal", steps.size(), 2);
        pin("jal_pcsrc", int'(steps[1].exp.pc_source), 2);
        build(6'h00, 6'h20, 3, 0, 2); pin("lat_fetch_stall", steps.size(), 7);
        // Directed sequence
        reset = 1'b0;
        run(6'h00, 6'h20, 0, 0, 2);
        run(6'h23, 6'h00, 0, 2, 2);
        run(6'h04, 6'h00, 0, 0, 1);
        run(6'h04, 6'h00, 0, 0, 0);
        run(6'h05, 6'h00, 0, 0, 0);
        run(6'h03, 6'h00, 0, 0, 2);
        run(6'h00, 6'h20, 3, 0, 2);
        run(6'h3F, 6'h00, 0, 0, 2);
        // Reset during a stalled store MEM cycle, ready high in that cycle
        build(6'h2B, 6'h00, 0, 3, 2);
        steps = steps[0:3];
        push(1'b1, 1'b1, 1'b0, ctl_t'(0));
        play(6'h2B, 6'h00);
        run(6'h0D, 6'h00, 0, 0, 2);
        // Randomised instruction stream
        for (int n = 0; n < 300; n++) begin
            int idx;
            idx = $urandom_range(0, 19);
            run(ilist[idx][11:6], ilist[idx][5:0], $urandom_range(0, 2),
                $urandom_range(0, 2), 2);
        end
        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
